// File: rtl/bram_pkg.sv
// Shared types and helpers for the block-RAM family.
// Covers the read-during-write mode selector and byte-lane count arithmetic.
package bram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    function automatic int num_lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read output pipeline for the RAM family.
// Turns stage-1 data/valid into dout/dout_valid with optional extra register and output hold.
module bram_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s1Data_i,
    input  logic                  s1Valid_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  doutValid_o
);

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2Data_q;
        logic                  s2Valid_q;

        // Stage 2 only captures real reads, so dout holds the last completed word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2Data_q  <= '0;
                s2Valid_q <= 1'b0;
            end else begin
                s2Valid_q <= s1Valid_i;
                if (s1Valid_i) begin
                    s2Data_q <= s1Data_i;
                end
            end
        end

        assign dout_o      = s2Data_q;
        assign doutValid_o = s2Valid_q;
    end else begin : g_lat1
        logic unusedClkRst;
        assign unusedClkRst = clk ^ rst_n;

        assign dout_o      = s1Data_i;
        assign doutValid_o = s1Valid_i;
    end

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane writes, read enable with hold,
// selectable read-during-write behaviour and 1- or 2-cycle read latency.
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int        DATA_WIDTH   = 32,
    parameter int        BYTE_WIDTH   = 8,
    parameter int        ADDR_WIDTH   = 10,
    parameter int        DEPTH        = 1 << ADDR_WIDTH,
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE     = RDW_READ_FIRST
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid
);

    localparam int LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_errLanes
        $error("bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_errLatency
        $error("bram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_errDepth
        $error("bram_sdp_be: DEPTH must be within 1..2**ADDR_WIDTH");
    end

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wrInRange;
    logic                  rdInRange;
    logic [DATA_WIDTH-1:0] rdWord;
    logic [DATA_WIDTH-1:0] s1Data_d;
    logic [DATA_WIDTH-1:0] s1Data_q;
    logic                  s1Valid_q;

    assign wrInRange = ({1'b0, wr_addr} < DEPTH_W);
    assign rdInRange = ({1'b0, rd_addr} < DEPTH_W);

    // Memory has no reset: writes land even while the read pipeline is held in reset.
    always_ff @(posedge clk) begin
        if (we && wrInRange) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Explicit write-first bypass; out-of-range reads return zero.
    always_comb begin
        rdWord = mem[rd_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && we && wrInRange && rd_addr == wr_addr) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    rdWord[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        s1Data_d = rdInRange ? rdWord : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Data_q  <= '0;
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= re;
            if (re) begin
                s1Data_q <= s1Data_d;
            end
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdPipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .s1Data_i    (s1Data_q),
        .s1Valid_i   (s1Valid_q),
        .dout_o      (dout),
        .doutValid_o (dout_valid)
    );

endmodule

// File: tb/tb_bram_sdp_be.sv
// Bench for bram_sdp_be: four instances (latency 1/2 x read-first/write-first, DEPTH=1000)
// share one stimulus stream and are compared every cycle against a word-level memory model.
module tb_bram_sdp_be;

    localparam int DEPTH = 1000;
    localparam int HIST  = 4096;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  wr_addr;
    logic [31:0] din;
    logic        re;
    logic [9:0]  rd_addr;

    logic [31:0] dout0, dout1, dout2, dout3;
    logic        valid0, valid1, valid2, valid3;
    logic [31:0] doutArr [4];
    logic        validArr [4];

    assign doutArr[0] = dout0;
    assign doutArr[1] = dout1;
    assign doutArr[2] = dout2;
    assign doutArr[3] = dout3;
    assign validArr[0] = valid0;
    assign validArr[1] = valid1;
    assign validArr[2] = valid2;
    assign validArr[3] = valid3;

    bram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(DEPTH),
                  .READ_LATENCY(1), .RDW_MODE(bram_pkg::RDW_READ_FIRST)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .din(din),
        .re(re), .rd_addr(rd_addr), .dout(dout0), .dout_valid(valid0));

    bram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(DEPTH),
                  .READ_LATENCY(2), .RDW_MODE(bram_pkg::RDW_READ_FIRST)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .din(din),
        .re(re), .rd_addr(rd_addr), .dout(dout1), .dout_valid(valid1));

    bram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(DEPTH),
                  .READ_LATENCY(1), .RDW_MODE(bram_pkg::RDW_WRITE_FIRST)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .din(din),
        .re(re), .rd_addr(rd_addr), .dout(dout2), .dout_valid(valid2));

    bram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(DEPTH),
                  .READ_LATENCY(2), .RDW_MODE(bram_pkg::RDW_WRITE_FIRST)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .we(we), .be(be), .wr_addr(wr_addr), .din(din),
        .re(re), .rd_addr(rd_addr), .dout(dout3), .dout_valid(valid3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [1024];
    bit          histValid [HIST];
    logic [31:0] histData [4][HIST];
    logic [31:0] lastDone [4];
    int          edgeCount;
    int          resetMark;
    int          checks;
    int          errors;

    function automatic int latOf(input int k);
        return (k % 2) + 1;
    endfunction

    function automatic bit writeFirstOf(input int k);
        return (k >= 2);
    endfunction

    // Word the read port must return for instance k, judged before this edge's write lands.
    function automatic logic [31:0] modelRead(input int k, input bit iWe, input logic [3:0] iBe,
                                              input logic [9:0] iWa, input logic [31:0] iDin,
                                              input logic [9:0] iRa);
        logic [31:0] w;
        if (int'(iRa) >= DEPTH) return 32'h0;
        w = model[iRa];
        if (writeFirstOf(k) && iWe && iWa == iRa) begin
            for (int i = 0; i < 4; i++) begin
                if (iBe[i]) w[i*8 +: 8] = iDin[i*8 +: 8];
            end
        end
        return w;
    endfunction

    function automatic logic [9:0] pickAddr();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 10'($urandom_range(0, 15));
        if (r == 1) return 10'($urandom_range(990, 999));
        return 10'($urandom_range(1000, 1023));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle();
        int src;
        bit expV;
        for (int k = 0; k < 4; k++) begin
            src = edgeCount - latOf(k) + 1;
            expV = (src > resetMark) && (src >= 0) && histValid[src];
            if (expV) lastDone[k] = histData[k][src];
            checkOutput($sformatf("valid%0d@%0d", k, edgeCount), {31'b0, validArr[k]}, {31'b0, expV});
            checkOutput($sformatf("dout%0d@%0d", k, edgeCount), doutArr[k], lastDone[k]);
        end
    endtask

    // One clock: drive inputs (called just after a falling edge), clock, update model, check.
    task automatic applyStimulus(input bit iWe, input logic [3:0] iBe, input logic [9:0] iWa,
                                 input logic [31:0] iDin, input bit iRe, input logic [9:0] iRa);
        we = iWe; be = iBe; wr_addr = iWa; din = iDin; re = iRe; rd_addr = iRa;
        for (int k = 0; k < 4; k++) histData[k][edgeCount + 1] = modelRead(k, iWe, iBe, iWa, iDin, iRa);
        @(posedge clk);
        edgeCount++;
        histValid[edgeCount] = iRe && rst_n;
        if (!rst_n) resetMark = edgeCount;
        if (iWe && int'(iWa) < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (iBe[i]) model[iWa][i*8 +: 8] = iDin[i*8 +: 8];
            end
        end
        @(negedge clk);
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    endtask

    task automatic startReset(input string tag);
        rst_n = 1'b0;
        resetMark = edgeCount;
        for (int k = 0; k < 4; k++) lastDone[k] = 32'h0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_dout%0d", tag, k), doutArr[k], 32'h0);
            checkOutput($sformatf("%s_valid%0d", tag, k), {31'b0, validArr[k]}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] wa;
        logic [9:0] ra;
        checks = 0;
        errors = 0;
        edgeCount = 0;
        resetMark = 0;
        for (int i = 0; i < HIST; i++) histValid[i] = 1'b0;
        we = 1'b0; be = 4'h0; wr_addr = '0; din = '0; re = 1'b0; rd_addr = '0;

        startReset("resetState");
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;

        // Only these addresses are ever read, so every read sees defined data.
        for (int a = 0; a < 16; a++)
            applyStimulus(1'b1, 4'hF, 10'(a), (a == 7) ? 32'h0 : $urandom, 1'b0, 10'd0);
        for (int a = 990; a < 1000; a++)
            applyStimulus(1'b1, 4'hF, 10'(a), $urandom, 1'b0, 10'd0);

        applyStimulus(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 10'd0);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        checkOutput("basicLat1", dout0, 32'hDEADBEEF);
        checkOutput("basicLat2NotYet", {31'b0, valid1}, 32'h0);
        idle(1);
        checkOutput("basicLat2", dout1, 32'hDEADBEEF);
        checkOutput("basicLat2Valid", {31'b0, valid1}, 32'h1);

        applyStimulus(1'b1, 4'hF, 10'd3, 32'h11223344, 1'b0, 10'd0);
        applyStimulus(1'b1, 4'b0101, 10'd3, 32'hAABBCCDD, 1'b0, 10'd0);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3);
        checkOutput("byteMerge", dout0, 32'h11BB33DD);

        applyStimulus(1'b1, 4'b0011, 10'd7, 32'hCAFEF00D, 1'b1, 10'd7);
        checkOutput("rdwReadFirst", dout0, 32'h00000000);
        checkOutput("rdwWriteFirst", dout2, 32'h0000F00D);
        idle(1);
        checkOutput("rdwWriteFirstLat2", dout3, 32'h0000F00D);

        for (int a = 0; a < 8; a++) applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(a));
        idle(5);
        checkOutput("holdLat1", dout0, 32'h0000F00D);
        checkOutput("holdLat2", dout1, 32'h0000F00D);

        applyStimulus(1'b1, 4'hF, 10'd1010, 32'h5A5A5A5A, 1'b0, 10'd0);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd1010);
        checkOutput("oorReadZero", dout0, 32'h0);
        checkOutput("oorReadValid", {31'b0, valid0}, 32'h1);
        applyStimulus(1'b1, 4'hF, 10'd999, 32'h0BADF00D, 1'b0, 10'd0);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd999);
        checkOutput("lastAddr", dout0, 32'h0BADF00D);
        idle(1);

        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        startReset("asyncRst");
        applyStimulus(1'b1, 4'hF, 10'd12, 32'h12345678, 1'b0, 10'd0);
        idle(1);
        rst_n = 1'b1;
        idle(3);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        idle(1);
        checkOutput("rstIntact", dout1, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd12);
        checkOutput("writeInReset", dout0, 32'h12345678);
        idle(1);

        for (int n = 0; n < 400; n++) begin
            wa = pickAddr();
            ra = ($urandom_range(0, 3) == 0) ? wa : pickAddr();
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom,
                          $urandom_range(0, 3) != 0, ra);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
